// File: rtl/cpu_halt_dump_ctrl_pkg.sv
// Shared types for the CPU end-of-program halt/dump controller.
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

    localparam int DBG_IDX_W  = 8;
    localparam int DBG_DATA_W = 32;

    // One register-dump word as seen on the debug stream.
    typedef struct packed {
        logic [DBG_IDX_W-1:0]  idx;
        logic [DBG_DATA_W-1:0] data;
    } dbg_word_t;

endpackage

// File: rtl/cpu_halt_dump_ctrl_halt_streak_det.sv
// Counts consecutive valid halt words in the ID stage; hit is high on the
// cycle the streak reaches HALT_COUNT (and stays high while halts continue).
module halt_streak_det
    import cpu_dbg_pkg::*;
#(
    parameter logic [31:0] HALT_INSTR = HALT_INSTR_DEFAULT,
    parameter int          HALT_COUNT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        hit
);

    localparam int            CW   = $clog2(HALT_COUNT + 1);
    localparam logic [CW-1:0] LAST = CW'(HALT_COUNT - 1);

    logic [CW-1:0] streak;
    logic          match;

    assign match = instr_valid && (instr == HALT_INSTR);
    assign hit   = match && (streak == LAST);

    // Streak saturates one short of HALT_COUNT so hit repeats on further halts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (!match) begin
            streak <= '0;
        end else if (streak != LAST) begin
            streak <= streak + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_halt_dump_ctrl.sv
// End-of-program controller: detects halt/dump/timeout, stalls the pipeline,
// drains in-flight writebacks, then streams the register file out.
module cpu_halt_dump_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int          DATA_W       = 32,
    parameter int          NUM_REGS     = 32,
    parameter int          IDX_W        = $clog2(NUM_REGS),
    parameter logic [31:0] HALT_INSTR   = HALT_INSTR_DEFAULT,
    parameter int          HALT_COUNT   = 10,
    parameter int          DRAIN_CYCLES = 4,
    parameter int          MAX_CYCLES   = 0,
    parameter bit          SKIP_ZERO    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    input  logic              dump_req,
    output logic [IDX_W-1:0]  rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              cpu_stall,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count,
    output state_e            dbg_state
);

    localparam int               DW       = $clog2(DRAIN_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    state_e           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [DW-1:0]    drain_cnt, drain_d;
    logic             timeout_d;
    logic             dump_req_q;
    logic             halt_hit, budget_hit, dump_rise, word_valid;

    halt_streak_det #(
        .HALT_INSTR (HALT_INSTR),
        .HALT_COUNT (HALT_COUNT)
    ) u_streak (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .hit         (halt_hit)
    );

    assign budget_hit = (MAX_CYCLES != 0) && (cycle_count == 32'(MAX_CYCLES - 1));
    assign dump_rise  = dump_req && !dump_req_q;
    assign word_valid = SKIP_ZERO ? (rf_rdata != '0) : 1'b1;

    // Stream handshake: a word transfers on a cycle with out_valid && out_ready;
    // once out_valid is up, idx (and therefore out_idx/out_data, read from the
    // frozen regfile) holds until that transfer. Zero words in skip mode
    // advance without ever raising out_valid.
    assign rf_raddr  = idx;
    assign out_idx   = idx;
    assign out_data  = rf_rdata;
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        state_d   = state;
        idx_d     = idx;
        drain_d   = drain_cnt;
        timeout_d = timeout;
        cpu_stall = 1'b1;
        out_valid = 1'b0;
        case (state)
            RUN: begin
                cpu_stall = 1'b0;
                if (halt_hit || dump_req || budget_hit) begin
                    state_d = DRAIN;
                    drain_d = DW'(DRAIN_CYCLES - 1);
                    if (budget_hit) timeout_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end else begin
                    drain_d = drain_cnt - DW'(1);
                end
            end
            DUMP: begin
                out_valid = word_valid;
                if (!word_valid || out_ready) begin
                    if (idx == LAST_IDX) state_d = DONE;
                    else                 idx_d   = idx + IDX_W'(1);
                end
            end
            DONE: begin
                if (dump_rise) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            idx         <= '0;
            drain_cnt   <= '0;
            timeout     <= 1'b0;
            dump_req_q  <= 1'b0;
            cycle_count <= '0;
        end else begin
            state      <= state_d;
            idx        <= idx_d;
            drain_cnt  <= drain_d;
            timeout    <= timeout_d;
            dump_req_q <= dump_req;
            if (state == RUN && cycle_count != 32'hFFFF_FFFF)
                cycle_count <= cycle_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_cpu_halt_dump_ctrl.sv
// Directed bench for cpu_halt_dump_ctrl: halt streaks, backpressure, skip-zero,
// timeout budget and asynchronous reset in the middle of a dump.
module tb_cpu_halt_dump_ctrl;
    import cpu_dbg_pkg::*;

    localparam int          NUM_REGS = 32;
    localparam int          IDX_W    = 5;
    localparam int          WORD_W   = $bits(dbg_word_t);
    localparam logic [31:0] HALT     = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    // ---------------- clock / reset / shared inputs ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        instr_valid;
    logic        dump_req;

    always #5 clk = ~clk;

    // ---------------- DUT A: SKIP_ZERO=0, MAX_CYCLES=100 ----------------
    logic [IDX_W-1:0] rf_raddr, out_idx;
    logic [31:0]      rf_rdata, out_data, cycle_count;
    logic             cpu_stall, out_valid, out_ready, done, timeout;
    state_e           dbg_state;
    logic [31:0]      rf_a [NUM_REGS];

    assign rf_rdata = rf_a[rf_raddr];

    cpu_halt_dump_ctrl #(
        .DATA_W(32), .NUM_REGS(NUM_REGS), .HALT_COUNT(10), .DRAIN_CYCLES(4),
        .MAX_CYCLES(100), .SKIP_ZERO(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .dump_req(dump_req), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .cpu_stall(cpu_stall), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_data(out_data), .done(done), .timeout(timeout),
        .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    // ---------------- DUT B: SKIP_ZERO=1, no timeout ----------------
    logic [IDX_W-1:0] rf_raddr_b, out_idx_b;
    logic [31:0]      rf_rdata_b, out_data_b, cycle_count_b;
    logic             cpu_stall_b, out_valid_b, out_ready_b, done_b, timeout_b;
    state_e           dbg_state_b;
    logic [31:0]      rf_b [NUM_REGS];

    assign rf_rdata_b = rf_b[rf_raddr_b];

    cpu_halt_dump_ctrl #(
        .DATA_W(32), .NUM_REGS(NUM_REGS), .HALT_COUNT(10), .DRAIN_CYCLES(4),
        .MAX_CYCLES(0), .SKIP_ZERO(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .dump_req(dump_req), .rf_raddr(rf_raddr_b), .rf_rdata(rf_rdata_b),
        .cpu_stall(cpu_stall_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_idx(out_idx_b), .out_data(out_data_b), .done(done_b), .timeout(timeout_b),
        .cycle_count(cycle_count_b), .dbg_state(dbg_state_b)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard on DUT A stream ----------------
    logic [WORD_W-1:0] exp_q[$];
    int               hs_cnt = 0;
    bit               mon_en = 1'b0;
    logic             prev_hold = 1'b0;
    logic [IDX_W-1:0] prev_idx;
    logic [31:0]      prev_data;

    always @(negedge clk) begin
        if (!mon_en || !reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_idx", out_idx, prev_idx);
                check("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                dbg_word_t w;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL extra_word: got idx %0d data %h, expected none", out_idx, out_data);
                end else begin
                    w = dbg_word_t'(exp_q.pop_front());
                    check("dump_idx", out_idx, 32'(w.idx));
                    check("dump_data", out_data, w.data);
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_idx  = out_idx;
            prev_data = out_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_exp();
        dbg_word_t w;
        exp_q.delete();
        for (int i = 0; i < NUM_REGS; i++) begin
            w.idx  = 8'(i);
            w.data = rf_a[i];
            exp_q.push_back(WORD_W'(w));
        end
        hs_cnt = 0;
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        instr       = NOP;
        instr_valid = 1'b0;
        dump_req    = 1'b0;
        out_ready   = 1'b1;
        mon_en      = 1'b0;
        #1;
        check("rst_stall", cpu_stall, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_cycles", cycle_count, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic pulse_dump();
        dump_req = 1'b1;
        @(posedge clk); #1;
        dump_req = 1'b0;
    endtask

    bit bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic wait_done(input int bound, input bit bp);
        int c;
        c = 0;
        while (!done && c < bound) begin
            if (bp) out_ready = bp_pat[c % 4];
            @(posedge clk); #1;
            c++;
        end
        check("done_within_bound", done, 1);
        out_ready = 1'b1;
    endtask

    // ---------------- RUN-phase vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        exp_stall;
        logic [31:0] exp_cycles;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(logic [31:0] i, logic v, logic st);
        vec_t x;
        x.instr      = i;
        x.valid      = v;
        x.exp_stall  = st;
        x.exp_cycles = 32'(vecs.size() + 1);
        vecs.push_back(x);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        out_ready_b = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            rf_a[i] = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            rf_b[i] = 32'h0;
        end

        // Streak broken by a nop and by a bubble; the tenth unbroken halt triggers.
        for (int k = 0; k < 5; k++) add_vec(HALT, 1'b1, 1'b0);
        add_vec(NOP, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) add_vec(HALT, 1'b1, 1'b0);
        add_vec(HALT, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) add_vec(HALT, 1'b1, 1'b0);
        add_vec(HALT, 1'b1, 1'b1);

        // ---- halt detection and full in-order dump ----
        do_reset();
        fill_exp();
        mon_en = 1'b1;
        foreach (vecs[k]) begin
            instr       = vecs[k].instr;
            instr_valid = vecs[k].valid;
            @(posedge clk); #1;
            check($sformatf("vec%0d_stall", k), cpu_stall, 32'(vecs[k].exp_stall));
            check($sformatf("vec%0d_cycles", k), cycle_count, vecs[k].exp_cycles);
        end
        instr_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("drain_no_valid", out_valid, 0);
            check("drain_stall", cpu_stall, 1);
        end
        @(posedge clk); #1;
        check("dump_first_valid", out_valid, 1);
        check("dump_first_idx", out_idx, 0);
        check("dump_state", dbg_state, DUMP);
        repeat (31) @(posedge clk);
        #1 check("done_not_early", done, 0);
        @(posedge clk); #1;
        check("done_after_idx31", done, 1);
        check("done_no_valid", out_valid, 0);
        check("t1_handshakes", 32'(hs_cnt), 32);
        check("t1_queue_empty", 32'(exp_q.size()), 0);
        check("t1_cycles_frozen", cycle_count, 26);
        check("t1_no_timeout", timeout, 0);

        // ---- backpressure 1,0,0,1 ----
        do_reset();
        for (int i = 0; i < NUM_REGS; i++) rf_a[i] = 32'(i) * 32'h9E37_79B9 + 32'h55;
        fill_exp();
        mon_en = 1'b1;
        pulse_dump();
        check("bp_stall", cpu_stall, 1);
        wait_done(400, 1'b1);
        check("bp_handshakes", 32'(hs_cnt), 32);
        check("bp_queue_empty", 32'(exp_q.size()), 0);

        // ---- skip-zero on DUT B ----
        do_reset();
        rf_b[1]  = 32'd5;
        rf_b[31] = 32'hDEAD_BEEF;
        pulse_dump();
        repeat (4) @(posedge clk);
        #1 check("skip_in_dump", dbg_state_b, DUMP);
        begin
            logic [31:0] got_idx [$];
            logic [31:0] got_data [$];
            for (int i = 0; i < NUM_REGS; i++) begin
                if (out_valid_b) begin
                    got_idx.push_back(32'(out_idx_b));
                    got_data.push_back(out_data_b);
                end
                if (i == NUM_REGS - 1) check("skip_done_not_early", done_b, 0);
                @(posedge clk); #1;
            end
            check("skip_done", done_b, 1);
            check("skip_word_count", 32'(got_idx.size()), 2);
            if (got_idx.size() == 2) begin
                check("skip_w0_idx", got_idx[0], 1);
                check("skip_w0_data", got_data[0], 5);
                check("skip_w1_idx", got_idx[1], 31);
                check("skip_w1_data", got_data[1], 32'hDEAD_BEEF);
            end
        end

        // ---- cycle budget timeout on DUT A ----
        do_reset();
        fill_exp();
        mon_en      = 1'b1;
        instr       = NOP;
        instr_valid = 1'b1;
        repeat (99) @(posedge clk);
        #1;
        check("to_pre_cycles", cycle_count, 99);
        check("to_pre_stall", cpu_stall, 0);
        check("to_pre_flag", timeout, 0);
        @(posedge clk); #1;
        check("to_stall", cpu_stall, 1);
        check("to_flag", timeout, 1);
        check("to_cycles", cycle_count, 100);
        wait_done(100, 1'b0);
        check("to_handshakes", 32'(hs_cnt), 32);
        check("to_cycles_held", cycle_count, 100);
        check("to_flag_sticky", timeout, 1);

        // ---- async reset mid-dump, then restart and re-stream ----
        do_reset();
        pulse_dump();
        begin
            int c;
            c = 0;
            while (!(out_valid && out_idx == 5'd7) && c < 60) begin
                @(posedge clk); #1;
                c++;
            end
            check("mid_reached_idx7", 32'(out_idx), 7);
        end
        #2 reset = 1'b0;
        #1;
        check("mid_rst_stall", cpu_stall, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_idx", out_idx, 0);
        check("mid_rst_raddr", rf_raddr, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_cycles", cycle_count, 0);
        check("mid_rst_state", dbg_state, RUN);
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("post_rst_cycles", cycle_count, 3);
        fill_exp();
        mon_en = 1'b1;
        pulse_dump();
        wait_done(100, 1'b0);
        check("post_rst_handshakes", 32'(hs_cnt), 32);
        repeat (3) @(posedge clk);
        #1 check("done_sticky", done, 1);
        fill_exp();
        pulse_dump();
        check("reentry_done_clear", done, 0);
        check("reentry_valid", out_valid, 1);
        check("reentry_idx", out_idx, 0);
        wait_done(100, 1'b0);
        check("reentry_handshakes", 32'(hs_cnt), 32);
        check("reentry_cycles_kept", cycle_count, 4);
        check("reentry_no_timeout", timeout, 0);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_halt_dump_ctrl.md
Name: cpu_halt_dump_ctrl

Overview:
Synthesizable end-of-program controller for the pipelined CPU (sccomp_dataflow). It watches the ID-stage instruction stream for a halt word held for a programmable number of cycles, or an external dump request, or a cycle-budget timeout. It then stalls the pipeline, waits for in-flight writebacks to drain, and streams the register file out over a valid/ready port. It replaces the bench-only halt counting and register printing with hardware usable on the board and in every ex-series bench.

Parameters:
DATA_W, 32, register data width
NUM_REGS, 32, registers streamed (power of two, >=2)
IDX_W, $clog2(NUM_REGS), index width (derived)
HALT_INSTR, 32'hFFFF_FFFF, halt encoding
HALT_COUNT, 10, consecutive valid halt cycles required (>=1)
DRAIN_CYCLES, 4, post-trigger wait before dumping (>=1; covers EX/MEM/WB)
MAX_CYCLES, 0, run-cycle budget; 0 disables timeout
SKIP_ZERO, 0, 1 = omit registers whose value is 0

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
instr  in  32  ID-stage instruction (instr_if_id)
instr_valid  in  1  instr is a real fetched instruction (not bubble)
dump_req  in  1  manual dump trigger, level, sampled per cycle
rf_raddr  out  IDX_W  regfile debug read address
rf_rdata  in  DATA_W  regfile debug read data, combinational from rf_raddr
cpu_stall  out  1  freeze PC and pipeline registers
out_valid  out  1  dump word valid
out_ready  in  1  consumer accepts
out_idx  out  IDX_W  register index of out_data
out_data  out  DATA_W  register value
done  out  1  dump complete (sticky)
timeout  out  1  MAX_CYCLES reached (sticky)
cycle_count  out  32  cycles spent in RUN, saturating

Behaviour:
- Reset (reset==0, async): state=RUN. Outputs cpu_stall=0, out_valid=0, out_idx=0, rf_raddr=0, done=0, timeout=0, cycle_count=0. Streak and drain counters are 0.
- Reset asserted in any state, mid-dump included, aborts immediately. No partial-handshake obligation.
- FSM: RUN, DRAIN, DUMP, DONE.
- RUN:
  - cycle_count increments each cycle and saturates at 32'hFFFF_FFFF.
  - Streak increments when instr_valid && instr==HALT_INSTR. It clears on any cycle without that match; a bubble also clears it.
  - Trigger on (a) the cycle streak reaches HALT_COUNT, (b) dump_req==1, or (c) MAX_CYCLES!=0 && cycle_count==MAX_CYCLES-1, which also sets timeout on the transition edge.
  - Simultaneous triggers produce one transition. timeout is set only if (c) is true.
  - On trigger: go to DRAIN, drain counter=DRAIN_CYCLES-1.
- DRAIN: cpu_stall=1. The counter decrements. At 0, go to DUMP with idx=0.
- DUMP:
  - cpu_stall=1, rf_raddr=idx, out_idx=idx, out_data=rf_rdata (combinational).
  - SKIP_ZERO=0: out_valid=1 every cycle.
  - SKIP_ZERO=1: out_valid = (rf_rdata!=0). A zero register advances idx in one cycle without asserting out_valid.
  - idx advances on (out_valid && out_ready) or on a skip.
  - out_idx/out_data are held stable while out_valid && !out_ready.
  - Advance at idx==NUM_REGS-1 goes to DONE. The index does not wrap.
- DONE: done=1, cpu_stall=1, out_valid=0. A rising edge of dump_req (registered previous value, 0 to 1) re-enters DUMP with idx=0. done clears on that re-entry. timeout and cycle_count are retained.
- Latency: halt seen continuously from cycle t triggers at the end of cycle t+HALT_COUNT-1. The first out_valid appears DRAIN_CYCLES cycles later.
- out_ready high in non-DUMP states is ignored.

Decomposition:
- Package cpu_dbg_pkg:
  - state enum {RUN, DRAIN, DUMP, DONE}
  - HALT_INSTR_DEFAULT = 32'hFFFF_FFFF
  - debug stream word struct {idx, data}
- Sub-module halt_streak_det (instr, instr_valid → hit pulse, parameter HALT_INSTR/HALT_COUNT). It is reused by benches.

Test Plan:
1. Halt detection, SKIP_ZERO=0, HALT_COUNT=10, out_ready=1: ten valid 32'hFFFFFFFF → cpu_stall high the next cycle. After 4 drain cycles, 32 words with out_idx 0..31 and data matching the regfile. done=1 one cycle after idx 31.
2. Interrupted streak: nine halts, one bubble, nine halts → no trigger. A tenth consecutive halt then triggers.
3. Backpressure: toggle out_ready 1,0,0,1 repeatedly during DUMP → each word held stable while stalled. No index skipped or duplicated. The total number of handshakes is 32.
4. SKIP_ZERO=1, regfile with only r1=5 and r31=32'hDEADBEEF nonzero → exactly 2 valid words: (1,5) and (31,DEADBEEF). done is asserted 32 DUMP cycles after entry.
5. Timeout: MAX_CYCLES=100, no halt → trigger at cycle_count==99. timeout=1, dump proceeds, cycle_count holds at 100.
6. Reset mid-DUMP at idx 7 → all outputs return to reset values asynchronously. After release, the block is in RUN with cycle_count=0. A dump_req pulse in DONE re-streams from idx 0.
